// File: rtl/register_rename.sv
// Rename stage: RAT lookup, free-list allocation/release and physical ready table.
module register_rename #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned AR_SIZE   = 7,
  parameter int unsigned AR_ARRAY  = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [4:0]                rs1_arch_in,
  input  logic [4:0]                rs2_arch_in,
  input  logic [4:0]                rd_arch_in,
  input  logic                      rd_write_in,
  input  logic                      wb_valid1_in,
  input  logic [AR_SIZE-1:0]        wb_phys1_in,
  input  logic                      wb_valid2_in,
  input  logic [AR_SIZE-1:0]        wb_phys2_in,
  input  logic                      retire_valid_in,
  input  logic [AR_SIZE-1:0]        retire_old_phys_in,
  output logic                      valid_out,
  output logic [AR_SIZE-1:0]        rs1_phys_out,
  output logic [AR_SIZE-1:0]        rs2_phys_out,
  output logic [AR_SIZE-1:0]        rd_phys_out,
  output logic [AR_SIZE-1:0]        old_rd_phys_out,
  output logic [AR_ARRAY-1:0]       reg_ready_out,
  output logic                      stall
);

  localparam int unsigned FL_DEPTH = AR_ARRAY - ARCH_REGS;
  localparam int unsigned CW       = AR_SIZE + 1;

  logic [AR_SIZE-1:0]  rat_q [ARCH_REGS];
  logic [AR_SIZE-1:0]  free_q [FL_DEPTH];
  logic [AR_SIZE-1:0]  head_q, head_d;
  logic [AR_SIZE-1:0]  tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AR_ARRAY-1:0] ready_q, ready_d;

  logic                valid_q;
  logic [AR_SIZE-1:0]  rs1_q, rs2_q, rd_q, old_q;
  logic [AR_SIZE-1:0]  rd_d, old_d;

  logic                wants_rd;
  logic                alloc;
  logic                push;
  logic [AR_SIZE-1:0]  free_head;

  // Circular pointer advance with wrap at the free-list depth.
  function automatic logic [AR_SIZE-1:0] ptr_inc(input logic [AR_SIZE-1:0] p);
    return (p == AR_SIZE'(FL_DEPTH - 1)) ? '0 : p + AR_SIZE'(1);
  endfunction

  // Allocation, release and next-state computation for pointers, count and ready table.
  always_comb begin
    wants_rd  = valid_in & rd_write_in & (rd_arch_in != 5'd0);
    stall     = wants_rd & (count_q == '0);
    alloc     = wants_rd & ~stall;
    push      = retire_valid_in & (retire_old_phys_in != '0) & (count_q != CW'(FL_DEPTH));
    free_head = free_q[head_q];

    head_d  = alloc ? ptr_inc(head_q) : head_q;
    tail_d  = push  ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    if (alloc && !push) begin
      count_d = count_q - CW'(1);
    end else if (push && !alloc) begin
      count_d = count_q + CW'(1);
    end

    rd_d  = alloc ? free_head : '0;
    old_d = alloc ? rat_q[rd_arch_in] : '0;

    // Writeback sets first so a same-index allocation clear takes priority.
    ready_d = ready_q;
    if (wb_valid1_in) ready_d[wb_phys1_in] = 1'b1;
    if (wb_valid2_in) ready_d[wb_phys2_in] = 1'b1;
    if (alloc)        ready_d[free_head]   = 1'b0;
    ready_d[0] = 1'b1;
  end

  // State and registered outputs; reset restores identity RAT and the full free list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= AR_SIZE'(i);
      end
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        free_q[i] <= AR_SIZE'(ARCH_REGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FL_DEPTH);
      ready_q <= '1;
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      old_q   <= '0;
    end else begin
      if (alloc) begin
        rat_q[rd_arch_in] <= free_head;
      end
      if (push) begin
        free_q[tail_q] <= retire_old_phys_in;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_in & ~stall;
      rs1_q   <= rat_q[rs1_arch_in];
      rs2_q   <= rat_q[rs2_arch_in];
      rd_q    <= rd_d;
      old_q   <= old_d;
    end
  end

  assign valid_out       = valid_q;
  assign rs1_phys_out    = rs1_q;
  assign rs2_phys_out    = rs2_q;
  assign rd_phys_out     = rd_q;
  assign old_rd_phys_out = old_q;
  assign reg_ready_out   = ready_q;

endmodule

// File: tb/tb_register_rename.sv
// Scoreboard bench for register_rename against a queue-based rename model.
module tb_register_rename;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [4:0]   rs1_arch_in, rs2_arch_in, rd_arch_in;
  logic         rd_write_in;
  logic         wb_valid1_in, wb_valid2_in;
  logic [6:0]   wb_phys1_in, wb_phys2_in;
  logic         retire_valid_in;
  logic [6:0]   retire_old_phys_in;
  logic         valid_out;
  logic [6:0]   rs1_phys_out, rs2_phys_out, rd_phys_out, old_rd_phys_out;
  logic [127:0] reg_ready_out;
  logic         stall;

  register_rename dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .rs1_arch_in(rs1_arch_in), .rs2_arch_in(rs2_arch_in), .rd_arch_in(rd_arch_in),
    .rd_write_in(rd_write_in),
    .wb_valid1_in(wb_valid1_in), .wb_phys1_in(wb_phys1_in),
    .wb_valid2_in(wb_valid2_in), .wb_phys2_in(wb_phys2_in),
    .retire_valid_in(retire_valid_in), .retire_old_phys_in(retire_old_phys_in),
    .valid_out(valid_out), .rs1_phys_out(rs1_phys_out), .rs2_phys_out(rs2_phys_out),
    .rd_phys_out(rd_phys_out), .old_rd_phys_out(old_rd_phys_out),
    .reg_ready_out(reg_ready_out), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    int           rs1, rs2, rd, old;
    logic [127:0] rdy;
  } exp_t;

  exp_t         sb[$];
  int           rat_m[32];
  logic [127:0] rdy_m;
  int           fl_m[$];
  int           pend_m[$];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = i;
    rdy_m = '1;
    fl_m.delete();
    for (int i = 32; i < 128; i++) fl_m.push_back(i);
    pend_m.delete();
    sb.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 0; rd_write_in = 0; rs1_arch_in = 0; rs2_arch_in = 0; rd_arch_in = 0;
    wb_valid1_in = 0; wb_valid2_in = 0; wb_phys1_in = 0; wb_phys2_in = 0;
    retire_valid_in = 0; retire_old_phys_in = 0;
    #1;
    checks++;
    if (reg_ready_out !== '1) begin
      errors++;
      $display("FAIL reset_ready: got %h expected all ones", reg_ready_out);
    end
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_rd", int'(rd_phys_out), 0);
    chk("reset_old", int'(old_rd_phys_out), 0);
    chk("reset_rs1", int'(rs1_phys_out), 0);
    chk("reset_stall", int'(stall), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle, check stall, advance the model and queue the expected response.
  task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit wr,
                      input bit w1v, input int w1, input bit w2v, input int w2,
                      input bit rv, input int rp);
    exp_t e;
    bit   exp_stall, alloc;
    int   presz;
    @(negedge clk);
    valid_in = v; rs1_arch_in = 5'(rs1); rs2_arch_in = 5'(rs2); rd_arch_in = 5'(rd);
    rd_write_in = wr;
    wb_valid1_in = w1v; wb_phys1_in = 7'(w1);
    wb_valid2_in = w2v; wb_phys2_in = 7'(w2);
    retire_valid_in = rv; retire_old_phys_in = 7'(rp);
    #1;
    presz     = fl_m.size();
    exp_stall = v && wr && (rd != 0) && (presz == 0);
    chk("stall", int'(stall), int'(exp_stall));
    alloc = v && wr && (rd != 0) && !exp_stall;
    e.v   = v && !exp_stall;
    e.rs1 = rat_m[rs1];
    e.rs2 = rat_m[rs2];
    if (w1v) rdy_m[w1] = 1'b1;
    if (w2v) rdy_m[w2] = 1'b1;
    if (alloc) begin
      e.rd  = fl_m.pop_front();
      e.old = rat_m[rd];
      rat_m[rd] = e.rd;
      rdy_m[e.rd] = 1'b0;
      pend_m.push_back(e.old);
    end else begin
      e.rd  = 0;
      e.old = 0;
    end
    if (rv && rp != 0 && presz < 96) fl_m.push_back(rp);
    rdy_m[0] = 1'b1;
    e.rdy = rdy_m;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every post-edge output against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid_out", int'(valid_out), int'(e.v));
        checks++;
        if (reg_ready_out !== e.rdy) begin
          errors++;
          $display("FAIL reg_ready: got %h expected %h", reg_ready_out, e.rdy);
        end
        if (e.v) begin
          chk("rs1_phys", int'(rs1_phys_out), e.rs1);
          chk("rs2_phys", int'(rs2_phys_out), e.rs2);
          chk("rd_phys", int'(rd_phys_out), e.rd);
          chk("old_rd_phys", int'(old_rd_phys_out), e.old);
        end
      end
    end
  end

  initial begin
    int rp, w1;
    bit rv, w1v;
    rst = 1'b1;
    reset_dut();

    // add x5,x1,x2
    step(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("add1_rs1", int'(rs1_phys_out), 1);
    chk("add1_rs2", int'(rs2_phys_out), 2);
    chk("add1_rd", int'(rd_phys_out), 32);
    chk("add1_old", int'(old_rd_phys_out), 5);
    chk("add1_ready32", int'(reg_ready_out[32]), 0);
    chk("add1_valid", int'(valid_out), 1);

    // add x6,x5,x5
    step(1, 5, 5, 6, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("add2_rs1", int'(rs1_phys_out), 32);
    chk("add2_rs2", int'(rs2_phys_out), 32);
    chk("add2_rd", int'(rd_phys_out), 33);

    step(0, 0, 0, 0, 0, 1, 32, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("wb_ready32", int'(reg_ready_out[32]), 1);

    // Drain the free list with no retire.
    for (int i = 0; i < 200 && fl_m.size() > 0; i++)
      step(1, $urandom_range(31), $urandom_range(31), $urandom_range(31, 1), 1, 0, 0, 0, 0, 0, 0);

    // Store and x0 write while empty: never stalled, no allocation.
    step(1, 3, 4, 9, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("store_rd", int'(rd_phys_out), 0);
    step(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("x0_old", int'(old_rd_phys_out), 0);

    // Stalled writer, with the oldest freed mapping retiring in the same cycle.
    rp = pend_m.pop_front();
    step(1, 3, 4, 7, 1, 0, 0, 0, 0, 1, rp);
    @(posedge clk); #2;
    chk("stalled_valid", int'(valid_out), 0);
    step(1, 3, 4, 7, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("unstall_rd", int'(rd_phys_out), 5);

    // Bring count to 1 and then alloc+retire every cycle across pointer wrap.
    rp = pend_m.pop_front();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rp);
    for (int i = 0; i < 200; i++) begin
      rp = pend_m.pop_front();
      step(1, $urandom_range(31), $urandom_range(31), $urandom_range(31, 1), 1,
           0, 0, 0, 0, 1, rp);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rv = 0; rp = 0;
      if (pend_m.size() > 0 && $urandom_range(1) == 1) begin
        rv = 1; rp = pend_m.pop_front();
      end else if ($urandom_range(15) == 0) begin
        rv = 1; rp = 0;
      end
      w1v = ($urandom_range(2) != 0);
      w1  = (fl_m.size() > 0 && $urandom_range(3) == 0) ? fl_m[0] : int'($urandom_range(127));
      step($urandom_range(3) != 0, $urandom_range(31), $urandom_range(31), $urandom_range(31),
           $urandom_range(4) != 0, w1v, w1, $urandom_range(1) == 1, w1, rv, rp);
    end

    // Mid-stream reset restores the full initial state.
    reset_dut();
    step(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("post_rst_rd", int'(rd_phys_out), 32);
    chk("post_rst_old", int'(old_rd_phys_out), 5);
    chk("post_rst_rs1", int'(rs1_phys_out), 1);
    for (int i = 0; i < 20; i++)
      step(1, $urandom_range(31), $urandom_range(31), $urandom_range(31), 1, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
